pipeline_ctrl: RTL

Central pipeline controller for the 6-stage core. It merges per-stage stall requests into the `stall[5:0]` vector consumed by every inter-stage register (bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = STOP). It also sequences exception flushes and drains a stale in-flight AXI-Lite instruction fetch after a flush. A stall watchdog and a stall-cycle performance counter complete the block.

---
 rtl/pipeline_ctrl_pkg.sv | 31 +++
 rtl/pipeline_ctrl_stall_watchdog.sv | 35 +++
 rtl/pipeline_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline controller: stall encodings,
// controller state codes and the priority encoder for stall requests.
package pipeline_ctrl_pkg;

  localparam logic STOP       = 1'b1;
  localparam logic NOT_STOP   = 1'b0;
  localparam logic RST_ENABLE = 1'b1;

  // Per-stage stop vectors: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    CTRL_RUN   = 1'b0,
    CTRL_DRAIN = 1'b1
  } ctrl_state_e;

  // The deepest stalling stage wins; every stage upstream of it stops too.
  function automatic logic [5:0] base_stall(input logic mem_req, input logic ex_req,
                                            input logic id_req, input logic if_req);
    if (mem_req)     return STALL_MEM;
    else if (ex_req) return STALL_EX;
    else if (id_req) return STALL_ID;
    else if (if_req) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles and raises a sticky flag
// once the run reaches TIMEOUT_CYCLES. The flag clears only on reset.
module pipeline_ctrl_stall_watchdog
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  output logic stall_timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Consecutive-stall counter, saturating at LIMIT; the flag sets on the edge
  // at which the counter reaches LIMIT and then holds.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt           <= '0;
      stall_timeout <= 1'b0;
    end else if (stalled == NOT_STOP) begin
      cnt <= '0;
    end else begin
      if (cnt != LIMIT) cnt <= cnt + 1'b1;
      if (cnt >= LIMIT - 1'b1) stall_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: merges stage stall requests, sequences
// exception flushes and drains a stale instruction fetch after a flush.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stallreq,
  input  logic        id_stallreq,
  input  logic        ex_stallreq,
  input  logic        mem_stallreq,
  input  logic        excp_valid,
  input  logic [31:0] excp_target,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        if_discard,
  output logic        stall_timeout,
  output logic [31:0] stall_cnt
);

  ctrl_state_e state, state_next;
  logic [5:0]  base;
  logic        flush_cond;

  assign base       = base_stall(mem_stallreq, ex_stallreq, id_stallreq, if_stallreq);
  // An exception cannot redirect while its MEM access is still on the bus.
  assign flush_cond = excp_valid && !mem_stallreq;

  // State register.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state <= CTRL_RUN;
    else                   state <= state_next;
  end

  // Next state and combinational stall/flush outputs.
  // NOTE: every output gets a default before any branch so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    stall      = STALL_NONE;
    flush      = 1'b0;
    new_pc     = 32'h0;
    if_discard = 1'b0;
    if (rst != RST_ENABLE) begin
      unique case (state)
        CTRL_RUN: begin
          if (flush_cond) begin
            flush  = 1'b1;
            new_pc = excp_target;
            // A fetch still outstanding at redirect returns stale data later.
            if (if_stallreq) state_next = CTRL_DRAIN;
          end else begin
            stall = base;
          end
        end
        CTRL_DRAIN: begin
          if_discard = 1'b1;
          if (flush_cond) begin
            flush  = 1'b1;
            new_pc = excp_target;
          end else begin
            // Hold PC and IF on the redirected PC until the bus is free.
            stall = base | STALL_IF;
            if (!if_stallreq) state_next = CTRL_RUN;
          end
        end
        default: state_next = CTRL_RUN;
      endcase
    end
  end

  // Performance counter of cycles with the PC stopped, saturating.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) stall_cnt <= 32'h0;
    else if (stall[0] == STOP && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
  end

  pipeline_ctrl_stall_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk          (clk),
    .rst          (rst),
    .stalled      (stall != STALL_NONE),
    .stall_timeout(stall_timeout)
  );

endmodule
